image_counter: RTL and testbench
================================

IMAGE_COUNTER -- requirements
Module: image_counter

Interface
REQ-001 Parameters SHALL be: CW, default 12, counter width; VS_POL, default 1, vsync active level; HS_POL, default 1, hsync active level; DE_POL, default 1, dvalid active level.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 arstn  input  1  reset; synchronous, active-high (port keeps codebase name).
REQ-004 vsync  input  1  frame sync from video source (e.g. color_bar vs).
REQ-005 hsync  input  1  line sync from video source (color_bar hs).
REQ-006 dvalid  input  1  active-pixel qualifier (color_bar de).
REQ-007 line_counter  output  CW  0-based index of current/most recent active line.
REQ-008 column_counter  output  CW  0-based index of most recently accepted pixel in line.
REQ-009 frame_width, frame_height  output  CW each  measured active size (present only with IMAGE_COUNTER_SIZE_EN).
REQ-010 frame_done  output  1  one-cycle pulse at frame end (present only with IMAGE_COUNTER_SIZE_EN).

Function
REQ-011 All inputs SHALL be registered once; polarity normalized via VS_POL/HS_POL/DE_POL; edges detected against the previous registered sample.
REQ-012 Pixel accepted on every cycle registered dvalid is active.
REQ-013 Line start = accepted pixel whose previous registered dvalid was inactive.
REQ-014 At line start column_counter SHALL load 0; at each further accepted pixel it SHALL increment by 1.
REQ-015 vsync active edge SHALL arm a first-line flag; at next line start line_counter SHALL load 0 and flag clears; at other line starts line_counter SHALL increment by 1.
REQ-016 Outputs SHALL update on the edge after the registered input sample (2 cycles input-to-output latency); hold value when dvalid inactive.
REQ-017 Both counters SHALL saturate at 2^CW-1, never wrap.
REQ-018 vsync edge coincident with line start: vsync takes priority, that line is line 0.
REQ-019 hsync SHALL only re-arm line-start detection (hsync active edge forces next accepted pixel to be a line start even if dvalid never dropped).
REQ-020 No vsync ever seen: line counting still runs from reset value 0 (first line after reset is line 0).

Reset
REQ-021 While arstn=1 at a clk edge: line_counter=0, column_counter=0, first-line flag set, all input/edge registers cleared to inactive, frame_width=0, frame_height=0, frame_done=0.
REQ-022 Reset asserted mid-line SHALL abandon the line; first pixel after release is line 0, column 0.

Configuration
REQ-023 Macro IMAGE_COUNTER_SIZE_EN: defined -> frame_width, frame_height, frame_done ports and logic exist; undefined -> ports and logic absent, REQ-007..REQ-008 behaviour unchanged.
REQ-024 With macro: at each line end (dvalid active->inactive) frame_width SHALL latch column_counter+1 (saturating).
REQ-025 With macro: at vsync active edge, if at least one line seen since previous vsync, frame_height SHALL latch line_counter+1 and frame_done SHALL pulse 1 cycle; otherwise both unchanged/0.

Verification
REQ-026 Reset pulse (arstn 1 for 2 cycles) mid-stream -> all outputs 0 next edge; first pixel after release gives line 0, column 0.
REQ-027 Frame of 4 lines x 8 pixels, vsync pulse before -> column_counter 0..7 per line, line_counter 0..3, both hold 7/3 in blanking.
REQ-028 Second identical frame -> line_counter returns to 0 on its first line; with SIZE_EN frame_width=8, frame_height=4, frame_done one pulse at second vsync edge.
REQ-029 CW=4, line of 20 pixels -> column_counter stops at 15.
REQ-030 Back-to-back lines with dvalid never dropping but hsync pulse between -> column restarts at 0, line increments.
REQ-031 color_bar source connected (hs/vs/de) -> counters track its active area; frame_width/height equal its active resolution.

Source files
------------

// File: rtl/image_counter.sv
// Video position counter: tracks line/column of accepted pixels from vsync/hsync/dvalid.
// Optional IMAGE_COUNTER_SIZE_EN adds measured frame_width/frame_height and a frame_done pulse.
module image_counter #(
  parameter int CW     = 12,
  parameter bit VS_POL = 1'b1,
  parameter bit HS_POL = 1'b1,
  parameter bit DE_POL = 1'b1
) (
  input  logic          clk,
  input  logic          arstn,
  input  logic          vsync,
  input  logic          hsync,
  input  logic          dvalid,
  output logic [CW-1:0] line_counter,
  output logic [CW-1:0] column_counter
`ifdef IMAGE_COUNTER_SIZE_EN
  ,
  output logic [CW-1:0] frame_width,
  output logic [CW-1:0] frame_height,
  output logic          frame_done
`endif
);

  localparam logic [CW-1:0] MAX = '1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == MAX) ? v : v + CW'(1);
  endfunction

  logic          vs_r_q, vs_r_d, hs_r_q, hs_r_d, de_r_q, de_r_d;
  logic          vs_p_q, vs_p_d, hs_p_q, hs_p_d, de_p_q, de_p_d;
  logic [CW-1:0] line_q, line_d, col_q, col_d;
  logic          first_q, first_d;
  logic          vs_rise, hs_rise, line_start;

`ifdef IMAGE_COUNTER_SIZE_EN
  logic [CW-1:0] width_q, width_d, height_q, height_d;
  logic          done_q, done_d, seen_q, seen_d;
  logic          line_end;
`endif

  always_comb begin
    // Normalise polarity so everything downstream is active-high.
    vs_r_d = ~(vsync ^ VS_POL);
    hs_r_d = ~(hsync ^ HS_POL);
    de_r_d = ~(dvalid ^ DE_POL);
    vs_p_d = vs_r_q;
    hs_p_d = hs_r_q;
    de_p_d = de_r_q;

    vs_rise    = vs_r_q & ~vs_p_q;
    hs_rise    = hs_r_q & ~hs_p_q;
    // An hsync edge splits a continuous dvalid run into a new line.
    line_start = de_r_q & (~de_p_q | hs_rise);

    line_d  = line_q;
    col_d   = col_q;
    first_d = first_q;
    if (line_start) begin
      col_d   = '0;
      line_d  = (first_q || vs_rise) ? '0 : sat_inc(line_q);
      first_d = 1'b0;
    end else begin
      if (de_r_q) col_d = sat_inc(col_q);
      if (vs_rise) first_d = 1'b1;
    end
  end

`ifdef IMAGE_COUNTER_SIZE_EN
  always_comb begin
    line_end = de_p_q & ~de_r_q;
    width_d  = width_q;
    height_d = height_q;
    done_d   = 1'b0;
    seen_d   = seen_q;
    if (line_end) width_d = sat_inc(col_q);
    // line_q still holds the previous frame's last line when vsync coincides with a line start.
    if (vs_rise && seen_q) begin
      height_d = sat_inc(line_q);
      done_d   = 1'b1;
    end
    if (line_start)   seen_d = 1'b1;
    else if (vs_rise) seen_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (arstn) begin
      width_q  <= '0;
      height_q <= '0;
      done_q   <= 1'b0;
      seen_q   <= 1'b0;
    end else begin
      width_q  <= width_d;
      height_q <= height_d;
      done_q   <= done_d;
      seen_q   <= seen_d;
    end
  end

  assign frame_width  = width_q;
  assign frame_height = height_q;
  assign frame_done   = done_q;
`endif

  always_ff @(posedge clk) begin
    if (arstn) begin
      vs_r_q  <= 1'b0;
      hs_r_q  <= 1'b0;
      de_r_q  <= 1'b0;
      vs_p_q  <= 1'b0;
      hs_p_q  <= 1'b0;
      de_p_q  <= 1'b0;
      line_q  <= '0;
      col_q   <= '0;
      first_q <= 1'b1;
    end else begin
      vs_r_q  <= vs_r_d;
      hs_r_q  <= hs_r_d;
      de_r_q  <= de_r_d;
      vs_p_q  <= vs_p_d;
      hs_p_q  <= hs_p_d;
      de_p_q  <= de_p_d;
      line_q  <= line_d;
      col_q   <= col_d;
      first_q <= first_d;
    end
  end

  assign line_counter   = line_q;
  assign column_counter = col_q;

endmodule

// File: tb/tb_image_counter.sv
// Directed bench for image_counter: main instance (CW=12) plus a CW=4 instance for saturation.
module tb_image_counter;
  logic clk = 1'b0;
  logic arstn, vsync, hsync, dvalid;
  logic [11:0] line_counter, column_counter;
  logic [3:0]  line4, col4;
`ifdef IMAGE_COUNTER_SIZE_EN
  logic [11:0] frame_width, frame_height;
  logic        frame_done;
  logic [3:0]  fw4, fh4;
  logic        fd4;
`endif

  always #5 clk = ~clk;

  image_counter #(.CW(12)) u_dut (
    .clk(clk), .arstn(arstn), .vsync(vsync), .hsync(hsync), .dvalid(dvalid),
    .line_counter(line_counter), .column_counter(column_counter)
`ifdef IMAGE_COUNTER_SIZE_EN
    , .frame_width(frame_width), .frame_height(frame_height), .frame_done(frame_done)
`endif
  );

  image_counter #(.CW(4)) u_dut4 (
    .clk(clk), .arstn(arstn), .vsync(vsync), .hsync(hsync), .dvalid(dvalid),
    .line_counter(line4), .column_counter(col4)
`ifdef IMAGE_COUNTER_SIZE_EN
    , .frame_width(fw4), .frame_height(fh4), .frame_done(fd4)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int d0;
  // Expectations for the two inputs still in flight (2-cycle latency).
  bit pv[2];
  int pl[2];
  int pc[2];
  int hl, hc;

`ifdef IMAGE_COUNTER_SIZE_EN
  always @(posedge clk) if (frame_done) done_cnt++;
`endif

  task automatic check_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic h, input logic d, input int el, input int ec);
    @(negedge clk);
    if (pv[1]) begin
      check_eq("line", int'(line_counter), pl[1]);
      check_eq("column", int'(column_counter), pc[1]);
      check_eq("column_cw4", int'(col4), (pc[1] > 15) ? 15 : pc[1]);
    end
    pv[1] = pv[0]; pl[1] = pl[0]; pc[1] = pc[0];
    pv[0] = 1'b1;  pl[0] = el;    pc[0] = ec;
    arstn = 1'b0; vsync = v; hsync = h; dvalid = d;
  endtask

  task automatic line(input int l, input int n);
    for (int p = 0; p < n; p++) drive(1'b0, 1'b0, 1'b1, l, p);
    hl = l; hc = n - 1;
  endtask

  task automatic blank(input int n, input logic v);
    for (int i = 0; i < n; i++) drive(v, 1'b0, 1'b0, hl, hc);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_line"}, int'(line_counter), 0);
    check_eq({tag, "_column"}, int'(column_counter), 0);
`ifdef IMAGE_COUNTER_SIZE_EN
    check_eq({tag, "_width"}, int'(frame_width), 0);
    check_eq({tag, "_height"}, int'(frame_height), 0);
    check_eq({tag, "_done"}, int'(frame_done), 0);
`endif
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    arstn = 1'b1;
    pv[0] = 1'b0; pv[1] = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    hl = 0; hc = 0;
  endtask

  initial begin
    arstn = 1'b1; vsync = 1'b0; hsync = 1'b0; dvalid = 1'b0;
    pv[0] = 1'b0; pv[1] = 1'b0;
    hl = 0; hc = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");

    // No vsync ever seen: first line is 0.
    line(0, 3); blank(3, 1'b0);
    line(1, 3); blank(2, 1'b0);
    line(2, 2);
    // Reset in the middle of a line with dvalid still high.
    rst_pulse();
    line(0, 3); blank(3, 1'b0);

    // Frame 1: vsync pulse then 4 lines x 8 pixels.
    blank(2, 1'b1); blank(2, 1'b0);
    for (int l = 0; l < 4; l++) begin
      line(l, 8); blank(3, 1'b0);
    end
`ifdef IMAGE_COUNTER_SIZE_EN
    check_eq("frame_width_f1", int'(frame_width), 8);
`endif

    // Frame 2: identical; exactly one frame_done pulse at its vsync.
    d0 = done_cnt;
    blank(2, 1'b1); blank(2, 1'b0);
`ifdef IMAGE_COUNTER_SIZE_EN
    check_eq("frame_done_pulses", done_cnt - d0, 1);
    check_eq("frame_height", int'(frame_height), 4);
`endif
    for (int l = 0; l < 4; l++) begin
      line(l, 8); blank(3, 1'b0);
    end
`ifdef IMAGE_COUNTER_SIZE_EN
    check_eq("frame_width_f2", int'(frame_width), 8);
`endif

    // 20-pixel line: CW=4 instance saturates column at 15.
    line(4, 20); blank(3, 1'b0);
`ifdef IMAGE_COUNTER_SIZE_EN
    check_eq("frame_width_20", int'(frame_width), 20);
    check_eq("frame_width_cw4", int'(fw4), 15);
`endif

    // dvalid never drops; hsync edge starts a new line.
    line(5, 4);
    drive(1'b0, 1'b1, 1'b1, 6, 0);
    drive(1'b0, 1'b1, 1'b1, 6, 1);
    drive(1'b0, 1'b0, 1'b1, 6, 2);
    drive(1'b0, 1'b0, 1'b1, 6, 3);
    hl = 6; hc = 3;
    blank(3, 1'b0);

    // vsync edge coincident with a line start: that line is line 0.
    drive(1'b1, 1'b0, 1'b1, 0, 0);
    drive(1'b1, 1'b0, 1'b1, 0, 1);
    drive(1'b1, 1'b0, 1'b1, 0, 2);
    hl = 0; hc = 2;
    blank(3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
